// File: rtl/signed_accumulator.sv
// Batch accumulator: sums COUNT signed samples with saturation and presents each
// finished sum on a valid/ready output held until the consumer takes it.
module signed_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_overflow,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    oflow_q, oflow_d;

    logic                    xfer;
    logic                    sat_ovf;
    logic signed [ACC_W-1:0] sat_sum;
    logic signed [ACC_W-1:0] in_sext;

    function automatic logic signed [ACC_W-1:0] sext_in(input logic signed [IN_W-1:0] x);
        return ACC_W'(x);
    endfunction

    // One guard bit is enough: a disagreeing top pair means the true sum left the ACC_W range.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [IN_W-1:0]  b);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            oflow_q <= oflow_d;
        end
    end

    assign xfer    = in_valid && in_ready;
    assign in_sext = sext_in(in_data);
    assign {sat_ovf, sat_sum} = sat_add(acc_q, in_data);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = (COUNT == 1) ? DONE : ACCUM;
            ACCUM:   if (xfer && (cnt_q + 1'b1 == LAST)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        oflow_d = oflow_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    acc_d = in_sext;
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                    if (COUNT == 1) begin
                        sum_d   = in_sext;
                        oflow_d = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d = sat_sum;
                    cnt_d = cnt_q + 1'b1;
                    ovf_d = ovf_q | sat_ovf;
                    if (cnt_q + 1'b1 == LAST) begin
                        sum_d   = sat_sum;
                        oflow_d = ovf_q | sat_ovf;
                    end
                end
            end
            DONE: begin
                // Result registers keep the last batch; only the working state is cleared.
                if (out_ready) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            default: begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_ready     = (state_q != DONE);
        out_valid    = (state_q == DONE);
        out_sum      = sum_q;
        out_overflow = oflow_q;
    end

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed bench for signed_accumulator: three instances (default, 16-sample, 5-bit
// accumulator) share one stimulus bus; each test watches the instance it targets.
module tb_signed_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, out_ready;
    logic [3:0] in_data;

    logic       rdy_a, vld_a, ovf_a;
    logic [7:0] sum_a;
    logic       rdy_b, vld_b, ovf_b;
    logic [7:0] sum_b;
    logic       rdy_c, vld_c, ovf_c;
    logic [4:0] sum_c;

    signed_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .out_sum(sum_a), .out_overflow(ovf_a),
        .out_valid(vld_a), .out_ready(out_ready));

    signed_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(16)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .out_sum(sum_b), .out_overflow(ovf_b),
        .out_valid(vld_b), .out_ready(out_ready));

    signed_accumulator #(.IN_W(4), .ACC_W(5), .COUNT(4)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_c), .out_sum(sum_c), .out_overflow(ovf_c),
        .out_valid(vld_c), .out_ready(out_ready));

    int         sel;
    logic       cur_rdy, cur_vld, cur_ovf;
    logic [7:0] cur_sum;

    always_comb begin
        cur_rdy = rdy_a;
        cur_vld = vld_a;
        cur_ovf = ovf_a;
        cur_sum = sum_a;
        if (sel == 1) begin
            cur_rdy = rdy_b; cur_vld = vld_b; cur_ovf = ovf_b; cur_sum = sum_b;
        end else if (sel == 2) begin
            cur_rdy = rdy_c; cur_vld = vld_c; cur_ovf = ovf_c; cur_sum = {3'b000, sum_c};
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; leaves the bench at the negedge after the sample's edge.
    task automatic feed(input string name, input logic [3:0] d);
        check({name, "_in_ready"}, cur_rdy, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_batch(input string name, input logic [63:0] smp, input int n,
                             input logic [7:0] exp_sum, input logic exp_ovf);
        for (int i = 0; i < n; i++) feed(name, smp[4*i +: 4]);
        check({name, "_out_valid"}, cur_vld, 1);
        check({name, "_out_sum"}, cur_sum, exp_sum);
        check({name, "_out_overflow"}, cur_ovf, exp_ovf);
        check({name, "_in_ready_done"}, cur_rdy, 0);
        @(negedge clk);
        check({name, "_valid_dropped"}, cur_vld, 0);
        check({name, "_ready_back"}, cur_rdy, 1);
    endtask

    typedef struct {
        string       name;
        int          sel;
        bit          do_rst;
        int          n;
        logic [63:0] smp;
        logic [7:0]  exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] fr;
        fr = '0;
        // Negated 0..15 as the upstream stage would present it.
        for (int i = 0; i < 16; i++) fr[4*i +: 4] = 4'((16 - i) % 16);

        vecs[0] = '{"basic",    0, 1'b1, 4,  64'h85F3, 8'hFF, 1'b0};
        vecs[1] = '{"fullrng",  1, 1'b1, 16, fr,       8'hF8, 1'b0};
        vecs[2] = '{"pos7",     0, 1'b1, 4,  64'h7777, 8'h1C, 1'b0};
        vecs[3] = '{"neg8",     0, 1'b1, 4,  64'h8888, 8'hE0, 1'b0};
        vecs[4] = '{"sat_pos",  2, 1'b1, 4,  64'h7777, 8'h0F, 1'b1};
        vecs[5] = '{"after_sat",2, 1'b0, 4,  64'h1111, 8'h04, 1'b0};
        vecs[6] = '{"sat_neg",  2, 1'b1, 4,  64'h8888, 8'h10, 1'b1};

        sel       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;

        do_reset(2);
        check("rst_out_valid", vld_a, 0);
        check("rst_out_sum", sum_a, 8'h00);
        check("rst_out_overflow", ovf_a, 0);
        check("rst_in_ready", rdy_a, 1);

        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel;
            if (vecs[v].do_rst) do_reset(2);
            run_batch(vecs[v].name, vecs[v].smp, vecs[v].n, vecs[v].exp_sum, vecs[v].exp_ovf);
        end

        // Gapped input, then a held result while in_valid keeps pulsing.
        sel = 0;
        do_reset(2);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data  = 4'(k + 1);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 4'h7;
            if (k < 3) @(negedge clk);
        end
        check("gap_out_valid", cur_vld, 1);
        check("gap_out_sum", cur_sum, 8'h0A);
        for (int k = 0; k < 5; k++) begin
            in_data  = 4'h5;
            in_valid = (k % 2 == 0);
            @(negedge clk);
            check("hold_out_valid", cur_vld, 1);
            check("hold_out_sum", cur_sum, 8'h0A);
            check("hold_in_ready", cur_rdy, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", cur_vld, 0);
        check("handoff_sum_kept", cur_sum, 8'h0A);
        run_batch("post_hold", 64'h1111, 4, 8'h04, 1'b0);

        // Reset in the middle of a batch discards the partial sum.
        do_reset(2);
        feed("mid", 4'h5);
        feed("mid", 4'h6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_valid", cur_vld, 0);
        check("midrst_ready", cur_rdy, 1);
        run_batch("midrst", 64'h1111, 4, 8'h04, 1'b0);

        // Reset while a result is pending clears the outputs.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed("pend", 4'h7);
        check("pend_valid", cur_vld, 1);
        check("pend_sum", cur_sum, 8'h1C);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("donerst_valid", cur_vld, 0);
        check("donerst_sum", cur_sum, 8'h00);
        check("donerst_ovf", cur_ovf, 0);
        check("donerst_ready", cur_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
